dmem_responder: RTL and testbench

//  Data-memory slave answering the datapath memory stage (M). Accepts one load/store

---
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory slave for the M stage.
// Inserts WAIT_CYCLES wait states and performs byte-lane stores.
// Load data comes back right-justified and zero-filled.
// mem_stall holds the pipeline while a request is in flight.
//
// state | meaning
// IDLE  | waiting for mem_en; request fields are latched on the accepting edge
// BUSY  | counting wait states against the latched request
// DONE  | mem_ready pulse; rdata/err were captured on the edge entering this state
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam int         AW       = ADDR_WIDTH + 2;
    localparam logic [3:0] LAST_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      size_q, size_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [3:0]      wen_q, wen_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem_q [DEPTH];

    logic [1:0]      req_size;
    logic [AW-1:0]   req_addr;
    logic [3:0]      req_wen;
    logic [31:0]     req_wdata;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]      off;
    logic [4:0]      shamt;
    logic            req_err;
    logic [31:0]     old_word;
    logic [31:0]     shifted;
    logic [31:0]     load_val;
    logic [3:0]      lanes;
    logic [31:0]     wdata_sh;
    logic            commit;
    logic            we;

    // Upper address bits alias onto the same storage and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[31:AW];

    // In IDLE the live inputs are the request (needed when there are no wait states).
    always_comb begin
        req_size  = size_q;
        req_addr  = addr_q;
        req_wen   = wen_q;
        req_wdata = wdata_q;
        if (state_q == IDLE) begin
            req_size  = mem_size;
            req_addr  = mem_addr[AW-1:0];
            req_wen   = mem_wen;
            req_wdata = mem_wdata;
        end
    end

    // Next-state and request-latch logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (mem_en) begin
                    size_d  = mem_size;
                    addr_d  = mem_addr[AW-1:0];
                    wen_d   = mem_wen;
                    wdata_d = mem_wdata;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_CYCLES == 0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address decode, alignment check, read extraction and store lane steering.
    always_comb begin
        word_idx = req_addr[AW-1:2];
        off      = req_addr[1:0];
        shamt    = {off, 3'b000};
        case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = off[0];
            2'b10:   req_err = (off != 2'b00);
            default: req_err = 1'b1;
        endcase
        old_word = mem_q[word_idx];
        shifted  = old_word >> shamt;
        case (req_size)
            2'b00:   load_val = {24'd0, shifted[7:0]};
            2'b01:   load_val = {16'd0, shifted[15:0]};
            default: load_val = shifted;
        endcase
        lanes    = req_wen << off;
        wdata_sh = req_wdata << shamt;
        commit   = (state_d == DONE);
        we       = commit && !req_err && (req_wen != 4'd0) && rst;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (commit) begin
            rdata_d = req_err ? 32'd0 : load_val;
            err_d   = req_err;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wen_q   <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; stores commit on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_err   = err_q;
    assign mem_ready = (state_q == DONE);
    assign mem_stall = mem_en & ~mem_ready;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, hand sequences, and random traffic
// against a byte-level memory model. A second instance exercises the
// zero-wait-state build.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        en_a = 1'b0;
    logic [1:0]  size_a = 2'd0;
    logic [31:0] addr_a = 32'd0;
    logic [3:0]  wen_a = 4'd0;
    logic [31:0] wdata_a = 32'd0;
    logic [31:0] rdata_a;
    logic        ready_a, stall_a, err_a;

    logic        en_b = 1'b0;
    logic [1:0]  size_b = 2'd0;
    logic [31:0] addr_b = 32'd0;
    logic [3:0]  wen_b = 4'd0;
    logic [31:0] wdata_b = 32'd0;
    logic [31:0] rdata_b;
    logic        ready_b, stall_b, err_b;

    int checks = 0;
    int failures = 0;

    logic [31:0] mdl [1024];

    typedef struct {
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wd;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .mem_en(en_a), .mem_size(size_a), .mem_addr(addr_a),
        .mem_wen(wen_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a),
        .mem_ready(ready_a), .mem_stall(stall_a), .mem_err(err_a)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .mem_en(en_b), .mem_size(size_b), .mem_addr(addr_b),
        .mem_wen(wen_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
        .mem_ready(ready_b), .mem_stall(stall_b), .mem_err(err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: memory as bytes; a legal access reads 2**size bytes starting at the offset.
    function automatic void model_access(input logic [1:0] sz, input logic [31:0] addr,
                                         input logic [3:0] wen, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic er);
        int off = int'(addr[1:0]);
        int idx = int'(addr[11:2]);
        logic [31:0] w = mdl[idx];
        er = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
        rd = 32'd0;
        if (er) return;
        for (int i = 0; i < (1 << sz); i++) rd[8*i +: 8] = w[8*(off+i) +: 8];
        for (int i = 0; i < 4; i++) begin
            if (wen[i] && (off + i) < 4) w[8*(off+i) +: 8] = wd[8*i +: 8];
        end
        mdl[idx] = w;
    endfunction

    task automatic do_req(input logic [1:0] sz, input logic [31:0] addr, input logic [3:0] wen,
                          input logic [31:0] wd, input bit chk,
                          output logic [31:0] rd, output logic er);
        logic [31:0] erd;
        logic eer;
        int n;
        bit got, stall_ok;
        model_access(sz, addr, wen, wd, erd, eer);
        size_a = sz; addr_a = addr; wen_a = wen; wdata_a = wd; en_a = 1'b1;
        n = 0; got = 1'b0; stall_ok = 1'b1;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ready_a) begin
                got = 1'b1;
                if (stall_a) stall_ok = 1'b0;
            end else if (!stall_a) stall_ok = 1'b0;
        end
        rd = rdata_a; er = err_a; en_a = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL req_timeout actual=no_ready required=ready");
        end else if (chk) begin
            check("latency", 32'(n), 32'd3);
            check("stall_during_req", 32'(stall_ok), 32'd1);
            check("model_rdata", rd, erd);
            check("model_err", 32'(er), 32'(eer));
        end
        @(posedge clk); #1;
        if (got && chk) check("ready_one_cycle", 32'(ready_a), 32'd0);
    endtask

    task automatic do_req0(input logic [1:0] sz, input logic [31:0] addr, input logic [3:0] wen,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er,
                           output int n);
        bit got;
        size_b = sz; addr_b = addr; wen_b = wen; wdata_b = wd; en_b = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ready_b) got = 1'b1;
        end
        rd = rdata_b; er = err_b; en_b = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL req0_timeout actual=no_ready required=ready");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t tbl[$];
        logic [31:0] rd;
        logic er;
        int n, pulses, extra;
        bit got, stall_ok;

        // Reset state
        #12;
        check("rst_rdata", rdata_a, 32'd0);
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_ready0", 32'(ready_b), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Give every word used below a known value
        for (int i = 0; i < 64; i++) begin
            do_req(2'd2, 32'(i * 4), 4'hF, $urandom, 1'b0, rd, er);
        end

        tbl.push_back(vec_t'{2'd2, 32'h20,   4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0});
        tbl.push_back(vec_t'{2'd2, 32'h20,   4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0});
        tbl.push_back(vec_t'{2'd0, 32'h23,   4'h1, 32'h00000055, 1'b1, 32'h000000DE, 1'b0});
        tbl.push_back(vec_t'{2'd0, 32'h23,   4'h0, 32'h0,        1'b1, 32'h00000055, 1'b0});
        tbl.push_back(vec_t'{2'd2, 32'h20,   4'h0, 32'h0,        1'b1, 32'h55ADBEEF, 1'b0});
        tbl.push_back(vec_t'{2'd1, 32'h22,   4'h0, 32'h0,        1'b1, 32'h000055AD, 1'b0});
        tbl.push_back(vec_t'{2'd1, 32'h21,   4'h3, 32'h00001234, 1'b1, 32'h0,        1'b1});
        tbl.push_back(vec_t'{2'd2, 32'h22,   4'h0, 32'h0,        1'b1, 32'h0,        1'b1});
        tbl.push_back(vec_t'{2'd3, 32'h20,   4'hF, 32'h0,        1'b1, 32'h0,        1'b1});
        tbl.push_back(vec_t'{2'd2, 32'h20,   4'h0, 32'h0,        1'b1, 32'h55ADBEEF, 1'b0});
        tbl.push_back(vec_t'{2'd2, 32'h1020, 4'h0, 32'h0,        1'b1, 32'h55ADBEEF, 1'b0});
        tbl.push_back(vec_t'{2'd0, 32'h21,   4'h0, 32'h0,        1'b1, 32'h000000BE, 1'b0});
        tbl.push_back(vec_t'{2'd1, 32'h20,   4'h0, 32'h0,        1'b1, 32'h0000BEEF, 1'b0});
        foreach (tbl[i]) begin
            do_req(tbl[i].sz, tbl[i].addr, tbl[i].wen, tbl[i].wd, 1'b1, rd, er);
            if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
        end

        // Back-to-back: mem_en held high over four loads
        size_a = 2'd2; addr_a = 32'h20; wen_a = 4'h0; wdata_a = 32'd0; en_a = 1'b1;
        pulses = 0; stall_ok = 1'b1; n = 0;
        while (pulses < 4 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (stall_a !== (en_a & ~ready_a) || stall_a === ready_a) stall_ok = 1'b0;
            if (ready_a) begin
                pulses++;
                check("b2b_rdata", rdata_a, 32'h55ADBEEF);
                if (pulses == 4) en_a = 1'b0;
            end
        end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready_a) extra++;
        end
        check("b2b_pulses", 32'(pulses), 32'd4);
        check("b2b_cycles", 32'(n), 32'd15);
        check("b2b_extra", 32'(extra), 32'd0);
        check("b2b_stall", 32'(stall_ok), 32'd1);

        // mem_en dropped during BUSY: store still completes
        size_a = 2'd2; addr_a = 32'h30; wen_a = 4'hF; wdata_a = 32'h0BADCAFE; en_a = 1'b1;
        model_access(2'd2, 32'h30, 4'hF, 32'h0BADCAFE, rd, er);
        @(posedge clk); #1;
        en_a = 1'b0;
        addr_a = 32'h40; wdata_a = 32'h0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (ready_a) got = 1'b1;
        end
        check("drop_en_ready", 32'(got), 32'd1);
        @(posedge clk); #1;
        do_req(2'd2, 32'h30, 4'h0, 32'h0, 1'b1, rd, er);
        check("drop_en_commit", rd, 32'h0BADCAFE);

        // Reset in the middle of a store abandons it
        do_req(2'd2, 32'h10, 4'hF, 32'h11112222, 1'b1, rd, er);
        do_req(2'd2, 32'h10, 4'h0, 32'h0, 1'b1, rd, er);
        check("pre_rst_lw", rd, 32'h11112222);
        size_a = 2'd2; addr_a = 32'h10; wen_a = 4'hF; wdata_a = 32'hCAFEF00D; en_a = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_rdata", rdata_a, 32'd0);
        check("midrst_ready", 32'(ready_a), 32'd0);
        check("midrst_err", 32'(err_a), 32'd0);
        en_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_req(2'd2, 32'h10, 4'h0, 32'h0, 1'b1, rd, er);
        check("post_rst_lw", rd, 32'h11112222);

        // Random traffic against the model
        for (int t = 0; t < 300; t++) begin
            logic [1:0]  sz;
            logic [3:0]  wen;
            logic [31:0] addr;
            sz   = 2'($urandom_range(0, 3));
            addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) wen = 4'h0;
            else if (sz == 2'd0) wen = 4'h1;
            else if (sz == 2'd1) wen = 4'h3;
            else wen = 4'hF;
            do_req(sz, addr, wen, $urandom, 1'b1, rd, er);
        end

        // Zero-wait-state build
        do_req0(2'd2, 32'h0, 4'hF, 32'hA5A50001, rd, er, n);
        check("w0_sw_latency", 32'(n), 32'd1);
        do_req0(2'd2, 32'h1000, 4'h0, 32'h0, rd, er, n);
        check("w0_alias_latency", 32'(n), 32'd1);
        check("w0_alias_rdata", rd, 32'hA5A50001);
        do_req0(2'd1, 32'h1002, 4'h3, 32'h00007777, rd, er, n);
        check("w0_sh_old", rd, 32'h0000A5A5);
        do_req0(2'd2, 32'h0, 4'h0, 32'h0, rd, er, n);
        check("w0_lw", rd, 32'h77770001);
        do_req0(2'd1, 32'h3, 4'h0, 32'h0, rd, er, n);
        check("w0_err", 32'(er), 32'd1);
        check("w0_err_rdata", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
